// File: rtl/fifo_pkg.sv
// Shared types and defaults for the single-port command FIFO and its initiator.
package fifo_pkg;

  localparam int unsigned FIFO_DATA_W   = 32;
  localparam int unsigned FIFO_CAPACITY = 7;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } fifo_master_state_t;

endpackage : fifo_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule : sat_counter

// File: rtl/fifo_port_master.sv
// Request/response initiator for the single-port command FIFO; rejects illegal
// reads/writes locally using a shadow occupancy count.
module fifo_port_master
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_W   = FIFO_DATA_W,
  parameter int unsigned CAPACITY = FIFO_CAPACITY,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [DATA_W-1:0]             req_data,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_write,
  output logic                          rsp_err,
  output logic [DATA_W-1:0]             rsp_data,
  output logic                          fifo_en,
  output logic                          fifo_r_w,
  output logic [DATA_W-1:0]             fifo_in,
  input  logic [DATA_W-1:0]             fifo_out,
  output logic [$clog2(CAPACITY+1)-1:0] occupancy,
  output logic [CNT_W-1:0]              wr_count,
  output logic [CNT_W-1:0]              rd_count,
  output logic [CNT_W-1:0]              err_count
);

  localparam int unsigned OCC_W = $clog2(CAPACITY + 1);

  fifo_master_state_t state;
  logic               lat_write;
  logic               req_illegal;
  logic               wr_inc;
  logic               rd_inc;
  logic               err_inc;

  assign req_illegal = req_write ? (occupancy == OCC_W'(CAPACITY))
                                 : (occupancy == '0);

  // Statistic strobes: successes count in ISSUE, rejections at the handshake.
  assign wr_inc  = (state == ISSUE) && lat_write;
  assign rd_inc  = (state == ISSUE) && !lat_write;
  assign err_inc = (state == IDLE) && req_valid && req_illegal;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      fifo_en   <= 1'b0;
      fifo_r_w  <= 1'b0;
      fifo_in   <= '0;
      occupancy <= '0;
      lat_write <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_write <= req_write;
            rsp_write <= req_write;
            req_ready <= 1'b0;
            if (req_illegal) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
              state     <= RESP;
            end else begin
              // fifo_in doubles as the latched write data
              fifo_en  <= 1'b1;
              fifo_r_w <= req_write;
              fifo_in  <= req_write ? req_data : '0;
              state    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          fifo_en   <= 1'b0;
          fifo_r_w  <= 1'b0;
          fifo_in   <= '0;
          occupancy <= lat_write ? (occupancy + OCC_W'(1)) : (occupancy - OCC_W'(1));
          state     <= WAIT;
        end
        WAIT: begin
          // FIFO output is only meaningful the cycle after the read command
          rsp_data  <= lat_write ? '0 : fifo_out;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_wr_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (wr_inc),
    .count (wr_count)
  );

  sat_counter #(.W(CNT_W)) u_rd_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (rd_inc),
    .count (rd_count)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (err_inc),
    .count (err_count)
  );

endmodule : fifo_port_master

// File: tb/tb_fifo_port_master.sv
// Self-checking bench for fifo_port_master with a behavioural FIFO on the command pins.
module tb_fifo_port_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic        rsp_err;
  logic [31:0] rsp_data;
  logic        fifo_en;
  logic        fifo_r_w;
  logic [31:0] fifo_in;
  logic [31:0] fifo_out;
  logic [2:0]  occupancy;
  logic [15:0] wr_count;
  logic [15:0] rd_count;
  logic [15:0] err_count;

  always #5 clk = ~clk;

  fifo_port_master dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_write (rsp_write),
    .rsp_err   (rsp_err),
    .rsp_data  (rsp_data),
    .fifo_en   (fifo_en),
    .fifo_r_w  (fifo_r_w),
    .fifo_in   (fifo_in),
    .fifo_out  (fifo_out),
    .occupancy (occupancy),
    .wr_count  (wr_count),
    .rd_count  (rd_count),
    .err_count (err_count)
  );

  // Behavioural FIFO: registered read data, zero whenever en is low; ov_en forces read data.
  logic [31:0] mq[$];
  logic        ov_en;
  logic [31:0] ov_val;

  always @(posedge clk) begin
    logic [31:0] w;
    if (reset) begin
      mq.delete();
      fifo_out <= '0;
    end else if (fifo_en && fifo_r_w) begin
      mq.push_back(fifo_in);
      fifo_out <= '0;
    end else if (fifo_en) begin
      w = (mq.size() > 0) ? mq.pop_front() : 32'h0;
      fifo_out <= ov_en ? ov_val : w;
    end else begin
      fifo_out <= '0;
    end
  end

  typedef struct {
    logic        wr;
    logic [31:0] data;
    logic        ov;
    logic [31:0] ovv;
    int          hold;
    logic        exp_err;
    logic [31:0] exp_data;
    logic [2:0]  exp_occ;
  } vec_t;

  typedef struct {
    logic        wr;
    logic        err;
    logic [31:0] data;
  } rsp_t;

  vec_t vecs[$];
  rsp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_wr   = 0;
  int   exp_rd   = 0;
  int   exp_errc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One request/response transaction with pin-level timing checks.
  task automatic txn(input logic wr, input logic [31:0] d, input logic exp_err,
                     input logic [31:0] exp_data, input int hold);
    rsp_t e;
    rsp_t got;
    int   k;
    int   en_cycles;
    bit   seen;
    bit   pins_bad;
    bit   rr_bad;
    bit   stable_bad;
    sb.push_back('{wr, exp_err, exp_data});
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_write = wr;
    req_data  = d;
    rsp_ready = (hold == 0);
    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_data  = '0;
    k = 0; seen = 0; en_cycles = 0; pins_bad = 0; rr_bad = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (req_ready) rr_bad = 1;
      if (fifo_en) begin
        en_cycles++;
        if (k != 1 || fifo_r_w !== wr || fifo_in !== (wr ? d : 32'h0)) pins_bad = 1;
      end else if (fifo_r_w !== 1'b0 || fifo_in !== 32'h0) begin
        pins_bad = 1;
      end
      if (rsp_valid) seen = 1;
    end
    check("rsp_latency", 64'(k), exp_err ? 64'd1 : 64'd3);
    check("fifo_en_cycles", 64'(en_cycles), exp_err ? 64'd0 : 64'd1);
    check("fifo_pins", pins_bad, 0);
    check("req_ready_busy", rr_bad, 0);
    if (!seen) begin
      e = sb.pop_front();
      rsp_ready = 1'b1;
      return;
    end
    got = '{rsp_write, rsp_err, rsp_data};
    stable_bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (!rsp_valid || req_ready || rsp_data !== got.data || rsp_err !== got.err ||
          rsp_write !== got.wr) stable_bad = 1;
    end
    if (hold > 0) begin
      check("hold_stable", stable_bad, 0);
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
    end
    e = sb.pop_front();
    check("rsp_write", rsp_write, e.wr);
    check("rsp_err", rsp_err, e.err);
    check("rsp_data", rsp_data, e.data);
    @(posedge clk); #1;
    @(negedge clk);
    check("req_ready_after", req_ready, 1);
    check("rsp_valid_after", rsp_valid, 0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_data = '0;
    rsp_ready = 1'b1; ov_en = 1'b0; ov_val = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_write", rsp_write, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_fifo_en", fifo_en, 0);
    check("rst_fifo_r_w", fifo_r_w, 0);
    check("rst_fifo_in", fifo_in, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_counts", {wr_count, rd_count, err_count}, 0);

    // wr, data, override, override value, hold, exp_err, exp_data, exp_occ
    vecs.push_back('{1'b1, 32'hDEADBEEF, 1'b0, 32'h0,        0, 1'b0, 32'h0,        3'd1});
    vecs.push_back('{1'b0, 32'hFFFFFFFF, 1'b1, 32'h12345678, 0, 1'b0, 32'h12345678, 3'd0});
    vecs.push_back('{1'b0, 32'h0,        1'b0, 32'h0,        0, 1'b1, 32'h0,        3'd0});
    for (int i = 1; i <= 7; i++)
      vecs.push_back('{1'b1, 32'hA0000000 + 32'(i), 1'b0, 32'h0, 0, 1'b0, 32'h0, 3'(i)});
    vecs.push_back('{1'b1, 32'hB0000008, 1'b0, 32'h0,        0, 1'b1, 32'h0,        3'd7});
    vecs.push_back('{1'b0, 32'h0,        1'b0, 32'h0,        0, 1'b0, 32'hA0000001, 3'd6});
    vecs.push_back('{1'b0, 32'h0,        1'b0, 32'h0,        5, 1'b0, 32'hA0000002, 3'd5});
    vecs.push_back('{1'b1, 32'hC0FFEE00, 1'b0, 32'h0,        0, 1'b0, 32'h0,        3'd6});

    foreach (vecs[i]) begin
      ov_en  = vecs[i].ov;
      ov_val = vecs[i].ovv;
      txn(vecs[i].wr, vecs[i].data, vecs[i].exp_err, vecs[i].exp_data, vecs[i].hold);
      ov_en = 1'b0;
      if (vecs[i].exp_err) exp_errc++;
      else if (vecs[i].wr) exp_wr++;
      else exp_rd++;
      check("occupancy", occupancy, vecs[i].exp_occ);
      check("wr_count", wr_count, 64'(exp_wr));
      check("rd_count", rd_count, 64'(exp_rd));
      check("err_count", err_count, 64'(exp_errc));
    end

    // Reset while a write sits in WAIT: transaction dropped, everything back to reset values.
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_data = 32'h55AA55AA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rstseq_issue_en", fifo_en, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rstseq_wait_occ", occupancy, 7);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rstseq_rsp_valid", rsp_valid, 0);
    check("rstseq_occupancy", occupancy, 0);
    check("rstseq_counts", {wr_count, rd_count, err_count}, 0);
    check("rstseq_req_ready", req_ready, 1);
    check("rstseq_fifo_en", fifo_en, 0);
    repeat (4) @(negedge clk);
    check("rstseq_no_rsp", rsp_valid, 0);

    txn(1'b1, 32'h00000042, 1'b0, 32'h0, 0);
    check("post_rst_occ", occupancy, 1);
    txn(1'b0, 32'h0, 1'b0, 32'h00000042, 0);
    check("post_rst_counts", {wr_count, rd_count, err_count}, {16'd1, 16'd1, 16'd0});
    check("sb_empty", 64'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fifo_port_master
